// File: rtl/jk_ff_bank_if.sv
// jk_ff_bank_if: control, data and status bundle of the JK flip-flop bank.
interface jk_ff_bank_if #(
    parameter int WIDTH = 8
);
    logic             en_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] j_i;
    logic [WIDTH-1:0] k_i;
    logic             ser_in_i;
    logic [WIDTH-1:0] q_o;
    logic [WIDTH-1:0] q_bar_o;
    logic             ser_out_o;
    logic             wrap_o;
    logic             changed_o;
    modport master (
        output en_i, mode_i, j_i, k_i, ser_in_i,
        input  q_o, q_bar_o, ser_out_o, wrap_o, changed_o
    );
    modport slave (
        input  en_i, mode_i, j_i, k_i, ser_in_i,
        output q_o, q_bar_o, ser_out_o, wrap_o, changed_o
    );
endinterface

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH JK flip-flops used as a JK bank, up/down counter or shift register.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    jk_ff_bank_if.slave bus
);
    logic [WIDTH-1:0] q_q, q_d, qb_q, up_t, dn_t, sh, jv, kv;
    logic             wrap_q, wrap_d, changed_q, changed_d;
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign up_t[i] = &q_q[i-1:0];
        assign dn_t[i] = ~|q_q[i-1:0];
    end
    assign sh = {q_q[WIDTH-2:0], bus.ser_in_i};
    // every mode is expressed as J/K drive so all bits share one JK update rule
    always_comb begin
        jv        = bus.mode_i == 2'b00 ? bus.j_i : bus.mode_i == 2'b01 ? up_t : bus.mode_i == 2'b10 ? dn_t : sh;
        kv        = bus.mode_i == 2'b00 ? bus.k_i : bus.mode_i == 2'b01 ? up_t : bus.mode_i == 2'b10 ? dn_t : ~sh;
        q_d       = bus.en_i ? ((jv & ~q_q) | (~kv & q_q)) : q_q;
        wrap_d    = bus.en_i & (((bus.mode_i == 2'b01) & (&q_q)) | ((bus.mode_i == 2'b10) & ~(|q_q)));
        changed_d = q_d != q_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RST_VAL;
            qb_q      <= ~RST_VAL;
            wrap_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            qb_q      <= ~q_d;
            wrap_q    <= wrap_d;
            changed_q <= changed_d;
        end
    end
    assign bus.q_o       = q_q;
    assign bus.q_bar_o   = qb_q;
    assign bus.ser_out_o = q_q[WIDTH-1];
    assign bus.wrap_o    = wrap_q;
    assign bus.changed_o = changed_q;
endmodule
